// File: rtl/fetch_latch_if.sv
// IF/ID boundary signals between the fetch side (PC block, imem) and the fetch latch.
// The latch is the slave; the fetch side or a bench drives through master.
interface fetch_latch_if #(
    parameter int unsigned WORD_W = 32
);
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] pc_plus_4;
    logic              stall;
    logic              flush;
    logic              imemREN;
    logic              pc_en;
    logic [WORD_W-1:0] instr_id;
    logic [WORD_W-1:0] npc_id;
    logic              valid_id;

    modport master (
        output ihit, imemload, pc_plus_4, stall, flush,
        input  imemREN, pc_en, instr_id, npc_id, valid_id
    );

    modport slave (
        input  ihit, imemload, pc_plus_4, stall, flush,
        output imemREN, pc_en, instr_id, npc_id, valid_id
    );
endinterface

// File: rtl/fetch_latch.sv
// IF/ID stage register with a one-entry skid buffer; throttles the PC and imem
// so a fetch that lands while decode is stalled is parked instead of dropped.
module fetch_latch #(
    parameter int unsigned          WORD_W    = 32,
    parameter logic [WORD_W-1:0]    NOP_INSTR = '0
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_latch_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] npc_q;
    logic              valid_q;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_npc;
    logic              accept;

    // Reset forces the read enable high and the PC frozen, regardless of flush.
    always_comb begin
        bus.imemREN = RST | ((state != SKID) & ~bus.flush);
        accept      = bus.ihit & bus.imemREN & ~RST;
        bus.pc_en   = ~RST & (bus.flush | accept);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= EMPTY;
            instr_q    <= NOP_INSTR;
            npc_q      <= '0;
            valid_q    <= 1'b0;
            skid_instr <= '0;
            skid_npc   <= '0;
        end else if (bus.flush) begin
            state   <= EMPTY;
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= FULL;
                        instr_q <= bus.imemload;
                        npc_q   <= bus.pc_plus_4;
                        valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.stall) begin
                        // Decode holds its word; a landing fetch is parked in the skid.
                        if (accept) begin
                            state      <= SKID;
                            skid_instr <= bus.imemload;
                            skid_npc   <= bus.pc_plus_4;
                        end
                    end else if (accept) begin
                        instr_q <= bus.imemload;
                        npc_q   <= bus.pc_plus_4;
                    end else begin
                        state   <= EMPTY;
                        instr_q <= NOP_INSTR;
                        npc_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                SKID: begin
                    if (!bus.stall) begin
                        state   <= FULL;
                        instr_q <= skid_instr;
                        npc_q   <= skid_npc;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    instr_q <= NOP_INSTR;
                    npc_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_id = instr_q;
    assign bus.npc_id   = npc_q;
    assign bus.valid_id = valid_q;

    a_invalid_is_empty_nop: assert property (
        @(posedge CLK) disable iff (RST)
        !valid_q |-> (state == EMPTY && instr_q == NOP_INSTR)
    );

endmodule

// File: tb/tb_fetch_latch.sv
// Directed bench for fetch_latch: per-scenario step tables, expected ID contents
// queued when each step is driven and compared after the capturing edge.
module tb_fetch_latch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic CLK;
    logic RST;

    fetch_latch_if #(.WORD_W(32)) bus ();

    fetch_latch #(.WORD_W(32), .NOP_INSTR(NOP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        ih;
        logic [31:0] d;
        logic [31:0] p;
        logic        st;
        logic        fl;
        logic [1:0]  cmb;   // {imemREN, pc_en} expected before the edge
        logic        v;
        logic [31:0] i;
        logic [31:0] n;
    } step_t;

    typedef struct {
        logic        v;
        logic [31:0] i;
        logic [31:0] n;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic apply(input step_t s);
        @(negedge CLK);
        bus.ihit      = s.ih;
        bus.imemload  = s.d;
        bus.pc_plus_4 = s.p;
        bus.stall     = s.st;
        bus.flush     = s.fl;
        sb.push_back('{s.v, s.i, s.n});
        #1;
    endtask

    task automatic test_reset();
        bus.ihit = 1'b1; bus.flush = 1'b1; bus.stall = 1'b0;
        bus.imemload = 32'hFFFF_FFFF; bus.pc_plus_4 = 32'h4;
        #2;
        n_cmp++;
        if ({bus.imemREN, bus.pc_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ren/pc_en=%b want 10", {bus.imemREN, bus.pc_en});
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.valid_id !== 1'b0 || bus.instr_id !== NOP || bus.npc_id !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_id: got v=%0b i=%h n=%h want v=0 i=%h n=0",
                     bus.valid_id, bus.instr_id, bus.npc_id, NOP);
        end
        @(negedge CLK);
        RST = 1'b0; bus.ihit = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_stream();
        step_t s[4];
        s = '{'{1'b1, 32'h2001_0001, 32'h4, 1'b0, 1'b0, 2'b11, 1'b1, 32'h2001_0001, 32'h4},
              '{1'b1, 32'h2002_0002, 32'h8, 1'b0, 1'b0, 2'b11, 1'b1, 32'h2002_0002, 32'h8},
              '{1'b1, 32'h2003_0003, 32'hC, 1'b0, 1'b0, 2'b11, 1'b1, 32'h2003_0003, 32'hC},
              '{1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0}};
        for (int k = 0; k < 4; k++) begin
            apply(s[k]);
            n_cmp++;
            if ({bus.imemREN, bus.pc_en} !== s[k].cmb) begin
                n_bad++;
                $display("FAIL stream_ctrl[%0d]: got %b want %b", k, {bus.imemREN, bus.pc_en}, s[k].cmb);
            end
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL stream_id[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
            if (e.v) begin
                n_cmp++;
                if (bus.npc_id !== e.n) begin
                    n_bad++;
                    $display("FAIL stream_npc[%0d]: got %h want %h", k, bus.npc_id, e.n);
                end
            end
        end
    endtask

    task automatic test_stall();
        step_t s[5];
        s = '{'{1'b1, 32'h1111_0001, 32'h10, 1'b0, 1'b0, 2'b11, 1'b1, 32'h1111_0001, 32'h10},
              '{1'b1, 32'h2222_0002, 32'h14, 1'b1, 1'b0, 2'b11, 1'b1, 32'h1111_0001, 32'h10},
              '{1'b1, 32'hDEAD_0003, 32'h18, 1'b1, 1'b0, 2'b00, 1'b1, 32'h1111_0001, 32'h10},
              '{1'b0, 32'h0,         32'h0,  1'b0, 1'b0, 2'b00, 1'b1, 32'h2222_0002, 32'h14},
              '{1'b0, 32'h0,         32'h0,  1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0}};
        for (int k = 0; k < 5; k++) begin
            apply(s[k]);
            n_cmp++;
            if ({bus.imemREN, bus.pc_en} !== s[k].cmb) begin
                n_bad++;
                $display("FAIL stall_ctrl[%0d]: got %b want %b", k, {bus.imemREN, bus.pc_en}, s[k].cmb);
            end
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL stall_id[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
            if (e.v) begin
                n_cmp++;
                if (bus.npc_id !== e.n) begin
                    n_bad++;
                    $display("FAIL stall_npc[%0d]: got %h want %h", k, bus.npc_id, e.n);
                end
            end
        end
    endtask

    task automatic test_flush_skid();
        step_t s[5];
        s = '{'{1'b1, 32'h3333_0001, 32'h20, 1'b0, 1'b0, 2'b11, 1'b1, 32'h3333_0001, 32'h20},
              '{1'b1, 32'h3333_0002, 32'h24, 1'b1, 1'b0, 2'b11, 1'b1, 32'h3333_0001, 32'h20},
              '{1'b1, 32'h4444_0044, 32'h28, 1'b1, 1'b1, 2'b01, 1'b0, NOP,          32'h0},
              '{1'b1, 32'h5555_0005, 32'h30, 1'b0, 1'b0, 2'b11, 1'b1, 32'h5555_0005, 32'h30},
              '{1'b0, 32'h0,         32'h0,  1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0}};
        for (int k = 0; k < 5; k++) begin
            apply(s[k]);
            n_cmp++;
            if ({bus.imemREN, bus.pc_en} !== s[k].cmb) begin
                n_bad++;
                $display("FAIL flush_skid_ctrl[%0d]: got %b want %b", k, {bus.imemREN, bus.pc_en}, s[k].cmb);
            end
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL flush_skid_id[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
            if (e.v) begin
                n_cmp++;
                if (bus.npc_id !== e.n) begin
                    n_bad++;
                    $display("FAIL flush_skid_npc[%0d]: got %h want %h", k, bus.npc_id, e.n);
                end
            end
        end
    endtask

    task automatic test_gaps();
        step_t s[4];
        s = '{'{1'b1, 32'h6001_0001, 32'h40, 1'b0, 1'b0, 2'b11, 1'b1, 32'h6001_0001, 32'h40},
              '{1'b0, 32'h6BAD_0BAD, 32'h44, 1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0},
              '{1'b1, 32'h6002_0002, 32'h48, 1'b0, 1'b0, 2'b11, 1'b1, 32'h6002_0002, 32'h48},
              '{1'b0, 32'h0,         32'h0,  1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0}};
        for (int k = 0; k < 4; k++) begin
            apply(s[k]);
            n_cmp++;
            if ({bus.imemREN, bus.pc_en} !== s[k].cmb) begin
                n_bad++;
                $display("FAIL gaps_ctrl[%0d]: got %b want %b", k, {bus.imemREN, bus.pc_en}, s[k].cmb);
            end
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL gaps_id[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
            if (e.v) begin
                n_cmp++;
                if (bus.npc_id !== e.n) begin
                    n_bad++;
                    $display("FAIL gaps_npc[%0d]: got %h want %h", k, bus.npc_id, e.n);
                end
            end
        end
    endtask

    task automatic test_flush_stall_full();
        step_t s[3];
        s = '{'{1'b1, 32'h6666_0006, 32'h50, 1'b0, 1'b0, 2'b11, 1'b1, 32'h6666_0006, 32'h50},
              '{1'b1, 32'h7777_0007, 32'h54, 1'b1, 1'b1, 2'b01, 1'b0, NOP,          32'h0},
              '{1'b0, 32'h0,         32'h0,  1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0}};
        for (int k = 0; k < 3; k++) begin
            apply(s[k]);
            n_cmp++;
            if ({bus.imemREN, bus.pc_en} !== s[k].cmb) begin
                n_bad++;
                $display("FAIL flush_full_ctrl[%0d]: got %b want %b", k, {bus.imemREN, bus.pc_en}, s[k].cmb);
            end
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL flush_full_id[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
        end
    endtask

    task automatic test_reset_mid_skid();
        step_t s[2];
        step_t t[2];
        s = '{'{1'b1, 32'h8888_0008, 32'h60, 1'b0, 1'b0, 2'b11, 1'b1, 32'h8888_0008, 32'h60},
              '{1'b1, 32'h9999_0009, 32'h64, 1'b1, 1'b0, 2'b11, 1'b1, 32'h8888_0008, 32'h60}};
        for (int k = 0; k < 2; k++) begin
            apply(s[k]);
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL rst_skid_setup[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
        end
        // Now holding a word in the skid; hit reset asynchronously mid-cycle.
        @(negedge CLK);
        bus.ihit = 1'b1; bus.stall = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.valid_id !== 1'b0 || bus.instr_id !== NOP || {bus.imemREN, bus.pc_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_skid_async: got v=%0b i=%h ren/pc_en=%b want v=0 i=%h 10",
                     bus.valid_id, bus.instr_id, {bus.imemREN, bus.pc_en}, NOP);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.valid_id !== 1'b0 || bus.instr_id !== NOP || bus.npc_id !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_skid_hold: got v=%0b i=%h n=%h want v=0 i=%h n=0",
                     bus.valid_id, bus.instr_id, bus.npc_id, NOP);
        end
        @(negedge CLK);
        RST = 1'b0;
        t = '{'{1'b1, 32'hAAAA_000A, 32'h70, 1'b0, 1'b0, 2'b11, 1'b1, 32'hAAAA_000A, 32'h70},
              '{1'b0, 32'h0,         32'h0,  1'b0, 1'b0, 2'b10, 1'b0, NOP,          32'h0}};
        for (int k = 0; k < 2; k++) begin
            apply(t[k]);
            n_cmp++;
            if ({bus.imemREN, bus.pc_en} !== t[k].cmb) begin
                n_bad++;
                $display("FAIL rst_skid_ctrl[%0d]: got %b want %b", k, {bus.imemREN, bus.pc_en}, t[k].cmb);
            end
            @(posedge CLK); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.valid_id !== e.v || bus.instr_id !== e.i) begin
                n_bad++;
                $display("FAIL rst_skid_after[%0d]: got v=%0b i=%h want v=%0b i=%h", k, bus.valid_id, bus.instr_id, e.v, e.i);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.ihit = 1'b0; bus.imemload = '0; bus.pc_plus_4 = '0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush_skid();
        test_gaps();
        test_flush_stall_full();
        test_reset_mid_skid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
